tnn_window_gen: RTL
===================

// Module: tnn_window_gen
// PURPOSE
//  Sliding 3x3 window generator for the TNN image path on the clk_a1 side.
//  Accepts the 64-bit pixel-vector stream produced by the 512->64 downsizer,
//  in raster order. Buffers two image rows and emits one 3x3 neighbourhood
//  (9 pixel vectors) per valid-padding position to the convolution core.
//  Neither side has backpressure: the downsizer runs with tready tied high.
// PARAMETERS
//  DW     64  bits per pixel vector (one stream beat)
//  IMG_W  32  pixels per row, >=3
//  IMG_H  32  rows per frame, >=3
// PORTS
//  aclk        in   1          clock (the clk_a1 domain at instantiation)
//  areset      in   1          async active-high reset
//  pix_in      in   DW         pixel vector, raster order, row-major
//  pix_in_vld  in   1          pixel beat; accepted every cycle it is high
//  win_out     out  9*DW       window; [DW*(3*r+c) +: DW], r0=top/oldest row, c0=left/oldest col
//  win_out_vld out  1          win_out holds a complete window this cycle
//  win_row     out  $clog2(IMG_H)  row index of window centre (r1)
//  win_col     out  $clog2(IMG_W)  col index of window centre (c1)
//  frame_done  out  1          1-cycle pulse with the last window of a frame
// BEHAVIOUR
//  - Reset clears: col/row counters = 0, win_out = 0, win_out_vld = 0,
//    win_row = 0, win_col = 0, frame_done = 0. Line buffers are not cleared.
//  - Counters advance only on pix_in_vld.
//    col goes 0..IMG_W-1; at IMG_W-1 it wraps to 0 and row increments.
//    At (IMG_W-1, IMG_H-1) both counters wrap to 0. A new frame follows with no gap.
//  - Two line buffers lb0 and lb1, each IMG_W x DW, with asynchronous read.
//    lb1 holds the row before last; lb0 holds the previous row.
//    On a beat at column col: read a = lb1[col], b = lb0[col].
//    Then write lb1[col] <= b and lb0[col] <= pix_in.
//  - Three column shift registers, one per window row, each 3 deep.
//    On a beat, column {a, b, pix_in} shifts in at c2 and c0 is dropped.
//    Top row takes a, middle takes b, bottom takes pix_in.
//  - Latency is 1 cycle from the beat. Registered outputs hold the window
//    whose bottom-right pixel is the beat.
//    win_out_vld = 1 iff beat had row>=2 && col>=2.
//    win_row = row-1, win_col = col-1.
//  - Stale shift-register columns from the previous row are never emitted,
//    because col<2 is masked.
//  - When win_out_vld=0, win_out/win_row/win_col hold their last value.
//    Contents are don't-care.
//  - frame_done = win_out_vld for the beat at (IMG_W-1, IMG_H-1).
//  - Gaps in pix_in_vld: state is frozen and win_out_vld=0 during the gap.
//    Output windows are bit-identical to the gap-free case.
//  - Windows per frame = (IMG_H-2)*(IMG_W-2). No padding, no output stall.
//  - Reset mid-frame: counters return to 0 immediately.
//    The next beat is pixel (0,0) of a new frame.
//    The first window appears at beat index 2*IMG_W+2 after reset.
//  - Simultaneous read/write of the same lb address in one beat: read returns
//    the old contents (write-after-read).
// TESTING
//  Use IMG_W=4, IMG_H=4, DW=64, pixel value = row*4+col.
//  1 Reset then 16 back-to-back beats.
//    -> First vld 1 cycle after beat 10, win = {0,1,2,4,5,6,8,9,10}, row=1, col=1.
//    -> Exactly 4 windows; last win = {5,6,7,9,10,11,13,14,15} with frame_done=1.
//  2 Same frame with pix_in_vld toggled 1,0,0,1,...
//    -> Same 4 windows in the same order.
//    -> vld only 1 cycle after valid beats; frame_done exactly once.
//  3 Two frames back to back, frame 2 values +100.
//    -> Frame 2 first window = {100,101,102,104,105,106,108,109,110}.
//    -> No frame-1 data appears in any frame 2 window.
//  4 Beats at col 0,1 of rows 2,3.
//    -> win_out_vld=0 for those beats; win_out unchanged.
//  5 Assert areset after beat 9 of frame 1, then stream a fresh frame.
//    -> All outputs 0 during reset.
//    -> Fresh frame yields exactly scenario 1's 4 windows.
//  6 IMG_W=32, IMG_H=32 random frame.
//    -> 900 windows, each compared against a software 3x3 model.
//    -> frame_done count = 1.

Source files
------------

// File: rtl/tnn_window_gen_if.sv
// ---------------------------------------------------------------------------
// tnn_window_gen_if
//   Groups the pixel stream into the window generator and the window stream
//   out of it into one bundle.
//   slave  : the window generator (consumes pixels, produces windows)
//   master : the environment (produces pixels, consumes windows)
//   Signals
//     pix_in      DW           pixel vector, raster order
//     pix_in_vld  1            pixel beat, accepted every cycle it is high
//     win_out     9*DW         3x3 window, word 3*r+c, r0/c0 = oldest
//     win_out_vld 1            win_out holds a complete window
//     win_row     clog2(IMG_H) row index of the window centre
//     win_col     clog2(IMG_W) col index of the window centre
//     frame_done  1            pulses with the last window of a frame
// ---------------------------------------------------------------------------
interface tnn_window_gen_if #(
  parameter int DW    = 64,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [DW-1:0]   pix_in;
  logic            pix_in_vld;
  logic [9*DW-1:0] win_out;
  logic            win_out_vld;
  logic [RW-1:0]   win_row;
  logic [CW-1:0]   win_col;
  logic            frame_done;

  modport slave (
    input  pix_in, pix_in_vld,
    output win_out, win_out_vld, win_row, win_col, frame_done
  );

  modport master (
    output pix_in, pix_in_vld,
    input  win_out, win_out_vld, win_row, win_col, frame_done
  );
endinterface

// File: rtl/tnn_window_gen.sv
// ---------------------------------------------------------------------------
// tnn_window_gen
//   Sliding 3x3 window generator. Takes a raster-order pixel-vector stream,
//   keeps the two previous rows in line buffers and emits one 3x3
//   neighbourhood per valid-padding position, one cycle after the beat that
//   completes it. No backpressure on either side.
//   Ports
//     aclk    clock
//     areset  asynchronous active-high reset
//     s       tnn_window_gen_if.slave (pixel stream in, window stream out)
// ---------------------------------------------------------------------------
module tnn_window_gen #(
  parameter int DW    = 64,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
) (
  input  logic              aclk,
  input  logic              areset,
  tnn_window_gen_if.slave   s
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [9*DW-1:0] win_q, win_d;
  logic            vld_q, vld_d;
  logic [RW-1:0]   win_row_q, win_row_d;
  logic [CW-1:0]   win_col_q, win_col_d;
  logic            done_q, done_d;

  // lb1 = row before last, lb0 = previous row
  logic [DW-1:0] lb0_q [IMG_W];
  logic [DW-1:0] lb1_q [IMG_W];
  // Column shift registers, word 3*r+c; c2 is the newest column
  logic [DW-1:0] sr_q [9];
  logic [DW-1:0] sr_d [9];
  logic [DW-1:0] rd_a, rd_b;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves a latch.
    rd_a      = lb1_q[col_q];
    rd_b      = lb0_q[col_q];
    col_d     = col_q;
    row_d     = row_q;
    sr_d      = sr_q;
    win_d     = win_q;
    win_row_d = win_row_q;
    win_col_d = win_col_q;
    vld_d     = 1'b0;
    done_d    = 1'b0;

    if (s.pix_in_vld) begin
      for (int r = 0; r < 3; r++) begin
        sr_d[3*r]   = sr_q[3*r+1];
        sr_d[3*r+1] = sr_q[3*r+2];
      end
      sr_d[2] = rd_a;
      sr_d[5] = rd_b;
      sr_d[8] = s.pix_in;

      // col<2 masks shift-register columns left over from the previous row
      if (row_q >= RW'(2) && col_q >= CW'(2)) begin
        vld_d = 1'b1;
        for (int i = 0; i < 9; i++) win_d[i*DW +: DW] = sr_d[i];
        win_row_d = row_q - RW'(1);
        win_col_d = col_q - CW'(1);
        done_d    = (col_q == COL_LAST) && (row_q == ROW_LAST);
      end

      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      col_q     <= '0;
      row_q     <= '0;
      win_q     <= '0;
      vld_q     <= 1'b0;
      win_row_q <= '0;
      win_col_q <= '0;
      done_q    <= 1'b0;
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      win_q     <= win_d;
      vld_q     <= vld_d;
      win_row_q <= win_row_d;
      win_col_q <= win_col_d;
      done_q    <= done_d;
    end
  end

  // NOTE: line buffers and shift registers carry no reset; their contents
  // are never emitted before being overwritten by the current frame.
  // Reading and writing lb[col] in the same beat returns the old word.
  always_ff @(posedge aclk) begin
    if (s.pix_in_vld) begin
      lb1_q[col_q] <= rd_b;
      lb0_q[col_q] <= s.pix_in;
      sr_q         <= sr_d;
    end
  end

  assign s.win_out     = win_q;
  assign s.win_out_vld = vld_q;
  assign s.win_row     = win_row_q;
  assign s.win_col     = win_col_q;
  assign s.frame_done  = done_q;
endmodule
